// File: rtl/mef_canal_sched_if.sv
// Channel-side bundle for mef_canal_sched: offered bits, grants, detect flags and alarm reporting.
interface mef_canal_sched_if #(
  parameter int unsigned N = 4
);
  localparam int unsigned CW = $clog2(N);

  logic [N-1:0]  E;
  logic [N-1:0]  V;
  logic          CNT_CLR;
  logic [N-1:0]  READY;
  logic [N-1:0]  Y;
  logic          ALARM;
  logic [CW-1:0] ALARM_CH;
  logic [7:0]    ALARM_CNT;

  modport master (
    output E, V, CNT_CLR,
    input  READY, Y, ALARM, ALARM_CH, ALARM_CNT
  );

  modport slave (
    input  E, V, CNT_CLR,
    output READY, Y, ALARM, ALARM_CH, ALARM_CNT
  );
endinterface

// File: rtl/mef_canal_sched.sv
// Round-robin time-shared zero-run detector: one accepted bit per cycle advances
// only its own channel's saved context; S4 entries raise an alarm and are counted.
module mef_canal_sched #(
  parameter int unsigned N = 4
) (
  input  logic              CLK,
  input  logic              CLR,
  mef_canal_sched_if.slave  bus
);
  localparam int unsigned CW      = $clog2(N);
  localparam logic [7:0]  CNT_MAX = 8'hFF;

  typedef enum logic [2:0] {
    S0 = 3'b000,
    S1 = 3'b001,
    S2 = 3'b010,
    S3 = 3'b011,
    S4 = 3'b100
  } ctx_t;

  ctx_t          ctx_q [N];
  logic [CW-1:0] ptr_q;
  logic          alarm_q;
  logic [CW-1:0] alarm_ch_q;
  logic [7:0]    alarm_cnt_q;

  logic          gvld_c;
  logic [CW-1:0] gidx_c;
  logic [N-1:0]  grant_c;
  int unsigned   idx_c;
  ctx_t          cur_c;
  ctx_t          nxt_c;
  logic          bit_c;
  logic          enter_c;
  logic [N-1:0]  y_c;

  // Round-robin search starting just after the last granted channel.
  always_comb begin
    gvld_c  = 1'b0;
    gidx_c  = '0;
    grant_c = '0;
    idx_c   = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx_c = (32'(ptr_q) + k) % N;
      if (!gvld_c && bus.V[CW'(idx_c)]) begin
        gvld_c = 1'b1;
        gidx_c = CW'(idx_c);
      end
    end
    if (gvld_c) grant_c[gidx_c] = 1'b1;
  end

  // Next context for the granted channel and S4-entry detection.
  always_comb begin
    cur_c   = ctx_q[gidx_c];
    bit_c   = bus.E[gidx_c];
    nxt_c   = S0;
    enter_c = 1'b0;
    case (cur_c)
      S0:      nxt_c = bit_c ? S0 : S1;
      S1:      nxt_c = bit_c ? S0 : S2;
      S2:      nxt_c = bit_c ? S0 : S3;
      S3:      nxt_c = bit_c ? S0 : S4;
      S4:      nxt_c = bit_c ? S0 : S3;
      default: nxt_c = S0;
    endcase
    enter_c = gvld_c && (cur_c != S4) && (nxt_c == S4);
  end

  // Detect flags decoded from the saved contexts.
  always_comb begin
    y_c = '0;
    for (int unsigned i = 0; i < N; i++) y_c[i] = (ctx_q[i] == S4);
  end

  // Per-channel context registers; only the granted one is written.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      for (int unsigned i = 0; i < N; i++) ctx_q[i] <= S0;
    end else begin
      for (int unsigned i = 0; i < N; i++) begin
        if (gvld_c && (gidx_c == CW'(i))) ctx_q[i] <= nxt_c;
      end
    end
  end

  // Arbitration pointer; reset to N-1 so channel 0 wins first.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR)         ptr_q <= CW'(N - 1);
    else if (gvld_c) ptr_q <= gidx_c;
  end

  // Alarm pulse, channel index hold and saturating counter with clear priority.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      alarm_q     <= 1'b0;
      alarm_ch_q  <= '0;
      alarm_cnt_q <= '0;
    end else begin
      alarm_q <= enter_c;
      if (enter_c) alarm_ch_q <= gidx_c;
      if (bus.CNT_CLR)                         alarm_cnt_q <= '0;
      else if (enter_c && alarm_cnt_q != CNT_MAX) alarm_cnt_q <= alarm_cnt_q + 8'd1;
    end
  end

  assign bus.READY     = grant_c;
  assign bus.Y         = y_c;
  assign bus.ALARM     = alarm_q;
  assign bus.ALARM_CH  = alarm_ch_q;
  assign bus.ALARM_CNT = alarm_cnt_q;
endmodule
